// File: rtl/seq_sensor_reporter.sv
// Multi-channel serial pattern reporter. Every channel owns a rate counter and a
// pattern matcher; hits are queued per channel and drained one report per cycle.

module seq_sensor_chan #(
    parameter int WIDTH = 8,
    parameter int PLEN  = 3,
    parameter int SAT   = 0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             fill_ok,
    input  logic             serve,
    input  logic [PLEN-1:0]  pat,
    input  logic [PLEN-1:0]  window,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] rate,
    output logic             pending,
    output logic [WIDTH-1:0] snap,
    output logic             miss
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   sum;
    logic             hit;

    assign sum = {1'b0, cnt} + {1'b0, rate};
    assign hit = en & fill_ok & (window == pat);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt     <= start_val;
            pending <= 1'b0;
            snap    <= '0;
            miss    <= 1'b0;
        end else begin
            if (SAT != 0 && sum[WIDTH])
                cnt <= '1;
            else
                cnt <= sum[WIDTH-1:0];
            // A hit on the channel being served re-arms it with the new snapshot.
            pending <= hit | (pending & ~serve);
            if (hit)
                snap <= cnt;
            if (hit && pending && !serve)
                miss <= 1'b1;
        end
    end
endmodule

module seq_sensor_reporter #(
    parameter int NCH   = 3,
    parameter int WIDTH = 8,
    parameter int PLEN  = 3,
    parameter int SAT   = 0,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  x,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH*PLEN-1:0]   pat,
    input  logic [NCH*WIDTH-1:0]  start_val,
    input  logic [NCH*WIDTH-1:0]  rate,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic [NCH-1:0]        miss
);
    localparam int FW = $clog2(PLEN + 1);

    logic [PLEN-2:0]             hist;
    logic [PLEN-1:0]             window;
    logic [FW-1:0]               fill;
    logic                        fill_ok;
    logic [NCH-1:0]              pending;
    logic [NCH-1:0]              serve;
    logic [NCH-1:0][WIDTH-1:0]   snap;
    logic [CHW-1:0]              sel;
    logic [WIDTH-1:0]            sel_snap;

    assign window  = {hist, x};
    assign fill_ok = (fill >= FW'(PLEN - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= window[PLEN-2:0];
            if (fill != FW'(PLEN))
                fill <= fill + FW'(1);
        end
    end

    // Lowest pending index wins; one-hot grant feeds back into the channels.
    assign serve = pending & (~pending + NCH'(1));

    always_comb begin
        sel      = '0;
        sel_snap = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel      = CHW'(i);
                sel_snap = snap[i];
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        seq_sensor_chan #(.WIDTH(WIDTH), .PLEN(PLEN), .SAT(SAT)) u_ch (
            .CLK       (CLK),
            .Reset     (Reset),
            .en        (ch_en[i]),
            .fill_ok   (fill_ok),
            .serve     (serve[i]),
            .pat       (pat[i*PLEN +: PLEN]),
            .window    (window),
            .start_val (start_val[i*WIDTH +: WIDTH]),
            .rate      (rate[i*WIDTH +: WIDTH]),
            .pending   (pending[i]),
            .snap      (snap[i]),
            .miss      (miss[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (|pending) begin
            out       <= sel_snap;
            out_ch    <= sel;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_sensor_reporter.sv
// Directed bench for seq_sensor_reporter: a wrapping instance and a saturating
// instance share all stimulus; expected reports are worked out by hand.

module tb_seq_sensor_reporter;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        x;
    logic [2:0]  ch_en;
    logic [8:0]  pat;
    logic [23:0] start_val;
    logic [23:0] rate;
    logic [7:0]  out, s_out;
    logic        out_valid, s_out_valid;
    logic [1:0]  out_ch, s_out_ch;
    logic [2:0]  miss, s_miss;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    seq_sensor_reporter #(.NCH(3), .WIDTH(8), .PLEN(3), .SAT(0)) dut (
        .CLK(CLK), .Reset(Reset), .x(x), .ch_en(ch_en), .pat(pat),
        .start_val(start_val), .rate(rate),
        .out(out), .out_valid(out_valid), .out_ch(out_ch), .miss(miss)
    );

    seq_sensor_reporter #(.NCH(3), .WIDTH(8), .PLEN(3), .SAT(1)) dut_sat (
        .CLK(CLK), .Reset(Reset), .x(x), .ch_en(ch_en), .pat(pat),
        .start_val(start_val), .rate(rate),
        .out(s_out), .out_valid(s_out_valid), .out_ch(s_out_ch), .miss(s_miss)
    );

    task automatic step(input logic xi);
        x = xi;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        x = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_default();
        ch_en     = 3'b111;
        pat       = {3'b101, 3'b010, 3'b111};
        start_val = {8'd27, 8'd53, 8'd46};
        rate      = {8'd8, 8'd1, 8'd3};
    endtask

    task automatic test_reset();
        set_default();
        Reset = 1'b1;
        x = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        checks++;
        if ({out_valid, out_ch, out} !== 11'd0)
            $display("FAIL reset_out: got v=%0b ch=%0d out=%0d, expected 0/0/0", out_valid, out_ch, out);
        else passed++;
        checks++;
        if (miss !== 3'b000 || s_miss !== 3'b000)
            $display("FAIL reset_miss: got %b/%b, expected 000/000", miss, s_miss);
        else passed++;
    endtask

    task automatic test_basic();
        set_default();
        do_reset();
        step(1); step(1); step(1);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL basic_e3: got v=%0b, expected 0", out_valid);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd0, 8'd52})
            $display("FAIL basic_e4: got v=%0b ch=%0d out=%0d, expected 1/0/52", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b0, 2'd0, 8'd52})
            $display("FAIL basic_hold: got v=%0b ch=%0d out=%0d, expected 0/0/52", out_valid, out_ch, out);
        else passed++;
    endtask

    task automatic test_simultaneous();
        set_default();
        pat = {3'b101, 3'b101, 3'b111};
        do_reset();
        step(1); step(0); step(1);
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd1, 8'd55})
            $display("FAIL simul_e4: got v=%0b ch=%0d out=%0d, expected 1/1/55", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd2, 8'd43})
            $display("FAIL simul_e5: got v=%0b ch=%0d out=%0d, expected 1/2/43", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, miss} !== 4'b0000)
            $display("FAIL simul_e6: got v=%0b miss=%b, expected 0/000", out_valid, miss);
        else passed++;
    endtask

    // ch0 pattern 001 would match the zero-filled window on edge 2 without the fill guard.
    task automatic test_fill_guard();
        set_default();
        pat = {3'b101, 3'b010, 3'b001};
        do_reset();
        step(0); step(1); step(0);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL fill_e3: got v=%0b ch=%0d out=%0d, expected no report", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd1, 8'd55})
            $display("FAIL fill_e4: got v=%0b ch=%0d out=%0d, expected 1/1/55", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL fill_e5: got v=%0b, expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_starvation();
        set_default();
        pat = {3'b111, 3'b010, 3'b111};
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k >= 4) begin
                checks++;
                if ({out_valid, out_ch, out} !== {1'b1, 2'd0, 8'(46 + 3 * (k - 2))})
                    $display("FAIL starve_e%0d: got v=%0b ch=%0d out=%0d, expected 1/0/%0d",
                             k, out_valid, out_ch, out, 46 + 3 * (k - 2));
                else passed++;
                checks++;
                if (miss !== 3'b100)
                    $display("FAIL starve_miss_e%0d: got %b, expected 100", k, miss);
                else passed++;
            end else if (k == 3) begin
                checks++;
                if (miss !== 3'b000)
                    $display("FAIL starve_miss_e3: got %b, expected 000", miss);
                else passed++;
            end
        end
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd0, 8'd67})
            $display("FAIL starve_e9: got v=%0b ch=%0d out=%0d, expected 1/0/67", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd2, 8'd83})
            $display("FAIL starve_e10: got v=%0b ch=%0d out=%0d, expected 1/2/83", out_valid, out_ch, out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, miss} !== 4'b0100)
            $display("FAIL starve_e11: got v=%0b miss=%b, expected 0/100", out_valid, miss);
        else passed++;
    endtask

    task automatic test_saturation();
        set_default();
        start_val[7:0] = 8'd250;
        rate[7:0]      = 8'd8;
        do_reset();
        step(1); step(1); step(1); step(1);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd0, 8'd10})
            $display("FAIL wrap_e4: got v=%0b ch=%0d out=%0d, expected 1/0/10", out_valid, out_ch, out);
        else passed++;
        checks++;
        if ({s_out_valid, s_out_ch, s_out} !== {1'b1, 2'd0, 8'd255})
            $display("FAIL sat_e4: got v=%0b ch=%0d out=%0d, expected 1/0/255", s_out_valid, s_out_ch, s_out);
        else passed++;
        step(0);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd0, 8'd18})
            $display("FAIL wrap_e5: got v=%0b ch=%0d out=%0d, expected 1/0/18", out_valid, out_ch, out);
        else passed++;
        checks++;
        if ({s_out_valid, s_out_ch, s_out} !== {1'b1, 2'd0, 8'd255})
            $display("FAIL sat_e5: got v=%0b ch=%0d out=%0d, expected 1/0/255", s_out_valid, s_out_ch, s_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        set_default();
        pat = {3'b111, 3'b111, 3'b010};
        do_reset();
        step(1); step(1); step(1); step(1); step(1);
        checks++;
        if ({out_valid, out_ch, out, miss} !== {1'b1, 2'd1, 8'd56, 3'b100})
            $display("FAIL rmid_e5: got v=%0b ch=%0d out=%0d miss=%b, expected 1/1/56/100",
                     out_valid, out_ch, out, miss);
        else passed++;
        do_reset();
        checks++;
        if ({out_valid, out_ch, out, miss} !== 14'd0)
            $display("FAIL rmid_reset: got v=%0b ch=%0d out=%0d miss=%b, expected all 0",
                     out_valid, out_ch, out, miss);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if ({out_valid, out} !== 9'd0)
                $display("FAIL rmid_drain_e%0d: got v=%0b out=%0d, expected 0/0", k, out_valid, out);
            else passed++;
        end
        step(1);
        checks++;
        if ({out_valid, out_ch, out} !== {1'b1, 2'd1, 8'd55})
            $display("FAIL rmid_reload: got v=%0b ch=%0d out=%0d, expected 1/1/55", out_valid, out_ch, out);
        else passed++;
    endtask

    initial begin
        Reset = 1'b1;
        x = 1'b0;
        set_default();
        test_reset();
        test_basic();
        test_simultaneous();
        test_fill_guard();
        test_starvation();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
